// File: rtl/vram_write_arbiter_pkg.sv
// Shared types and constants for the VRAM write path: display geometry defaults,
// the ILI9341 pixel type and the arbiter state encoding.
package vram_write_arbiter_pkg;

    typedef logic [15:0] ILI9341_color_t;
    localparam ILI9341_color_t BLACK = 16'h0000;

    localparam int DISPLAY_WIDTH_DEF  = 240;
    localparam int DISPLAY_HEIGHT_DEF = 320;
    localparam int VRAM_L_DEF         = DISPLAY_WIDTH_DEF * DISPLAY_HEIGHT_DEF;
    localparam int VRAM_AW_DEF        = $clog2(VRAM_L_DEF);
    localparam int COORD_W            = 9;
    localparam int N_REQ              = 2;

    typedef enum logic {
        S_VRAM_CLEARING = 1'b0,
        S_VRAM_ACTIVE   = 1'b1
    } vram_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        ILI9341_color_t     color;
    } vram_draw_t;

    // Out-of-range coordinates are still accepted by the arbiter but never written.
    function automatic logic coord_in_range(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input int                 width,
        input int                 height
    );
        return (int'(x) < width) && (int'(y) < height);
    endfunction

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Bundle between the two pixel requesters, the arbiter and the block_ram write port.
// master = requester/VRAM side, slave = the arbiter itself.
interface vram_write_arbiter_if
    import vram_write_arbiter_pkg::*;
#(
    parameter int AW     = VRAM_AW_DEF,
    parameter int VRAM_W = 16
);
    logic                    clear_req;
    logic [N_REQ-1:0]        draw_valid;
    vram_draw_t [N_REQ-1:0]  draw;
    logic [N_REQ-1:0]        draw_ready;
    logic                    vram_wr_ena;
    logic [AW-1:0]           vram_wr_addr;
    logic [VRAM_W-1:0]       vram_wr_data;
    logic                    busy;
    logic                    clear_done;

    modport slave (
        input  clear_req, draw_valid, draw,
        output draw_ready, vram_wr_ena, vram_wr_addr, vram_wr_data, busy, clear_done
    );

    modport master (
        output clear_req, draw_valid, draw,
        input  draw_ready, vram_wr_ena, vram_wr_addr, vram_wr_data, busy, clear_done
    );

endinterface

// File: rtl/vram_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant. The grant is combinational and doubles as the accept
// strobe, so last_grant moves only on an actual handshake.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_enable,
    output logic [1:0] o_grant
);
    logic r_last_grant;

    // Grant selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end else begin
            o_grant = 2'b00;
        end
    end

    // Remember who was served; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (o_grant[0]) begin
            r_last_grant <= 1'b0;
        end else if (o_grant[1]) begin
            r_last_grant <= 1'b1;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

endmodule

// File: rtl/vram_write_arbiter.sv
// Sole owner of the VRAM write port: full-screen clear after reset or on request,
// then round-robin pixel writes from two requesters with (x,y) -> linear address.
module vram_write_arbiter
    import vram_write_arbiter_pkg::*;
#(
    parameter int                DISPLAY_WIDTH  = DISPLAY_WIDTH_DEF,
    parameter int                DISPLAY_HEIGHT = DISPLAY_HEIGHT_DEF,
    parameter int                VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int                VRAM_W         = 16,
    parameter logic [VRAM_W-1:0] CLEAR_COLOR    = VRAM_W'(BLACK)
) (
    input  logic                 clk,
    input  logic                 rst,
    vram_write_arbiter_if.slave  bus
);
    localparam int            AW        = $clog2(VRAM_L);
    localparam logic [AW-1:0] LAST_ADDR = AW'(VRAM_L - 1);
    localparam logic [AW-1:0] ROW_PITCH = AW'(DISPLAY_WIDTH);

    vram_state_t       r_state;
    logic [AW-1:0]     r_clear_cnt;
    logic              r_wr_ena;
    logic [AW-1:0]     r_wr_addr;
    logic [VRAM_W-1:0] r_wr_data;
    logic              r_clear_done;

    vram_state_t       w_state_next;
    logic [AW-1:0]     w_clear_cnt_next;
    logic              w_wr_ena_next;
    logic [AW-1:0]     w_wr_addr_next;
    logic [VRAM_W-1:0] w_wr_data_next;
    logic              w_clear_done_next;

    logic              w_arb_enable;
    logic [1:0]        w_grant;
    logic              w_sel;
    vram_draw_t        w_sel_draw;
    logic              w_in_range;
    logic [AW-1:0]     w_draw_addr;

    // Draws are only offered in ACTIVE and lose to a same-cycle clear request or reset.
    assign w_arb_enable = (r_state == S_VRAM_ACTIVE) && !bus.clear_req && !rst;

    rr_arbiter2 u_rr_arbiter2 (
        .clk      (clk),
        .rst      (rst),
        .i_req    (bus.draw_valid),
        .i_enable (w_arb_enable),
        .o_grant  (w_grant)
    );

    assign w_sel       = w_grant[1];
    assign w_sel_draw  = bus.draw[w_sel];
    assign w_in_range  = coord_in_range(w_sel_draw.x, w_sel_draw.y, DISPLAY_WIDTH, DISPLAY_HEIGHT);
    // y < H guarantees y*W+x < L, so the AW-bit product cannot overflow when used.
    assign w_draw_addr = AW'(w_sel_draw.y) * ROW_PITCH + AW'(w_sel_draw.x);

    // Next-state and next-output logic for the clear / draw state machine.
    always_comb begin
        w_state_next      = r_state;
        w_clear_cnt_next  = r_clear_cnt;
        w_wr_ena_next     = 1'b0;
        w_wr_addr_next    = r_wr_addr;
        w_wr_data_next    = r_wr_data;
        w_clear_done_next = 1'b0;
        case (r_state)
            S_VRAM_CLEARING: begin
                w_wr_ena_next  = 1'b1;
                w_wr_addr_next = r_clear_cnt;
                w_wr_data_next = CLEAR_COLOR;
                if (r_clear_cnt == LAST_ADDR) begin
                    w_state_next      = S_VRAM_ACTIVE;
                    w_clear_cnt_next  = {AW{1'b0}};
                    w_clear_done_next = 1'b1;
                end else begin
                    w_clear_cnt_next  = r_clear_cnt + AW'(1);
                end
            end
            S_VRAM_ACTIVE: begin
                if (bus.clear_req) begin
                    w_state_next     = S_VRAM_CLEARING;
                    w_clear_cnt_next = {AW{1'b0}};
                end else if ((|w_grant) && w_in_range) begin
                    w_wr_ena_next  = 1'b1;
                    w_wr_addr_next = w_draw_addr;
                    w_wr_data_next = VRAM_W'(w_sel_draw.color);
                end else begin
                    w_wr_ena_next  = 1'b0;
                end
            end
            default: begin
                w_state_next     = S_VRAM_CLEARING;
                w_clear_cnt_next = {AW{1'b0}};
            end
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_VRAM_CLEARING;
            r_clear_cnt  <= {AW{1'b0}};
            r_wr_ena     <= 1'b0;
            r_wr_addr    <= {AW{1'b0}};
            r_wr_data    <= {VRAM_W{1'b0}};
            r_clear_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_clear_cnt  <= w_clear_cnt_next;
            r_wr_ena     <= w_wr_ena_next;
            r_wr_addr    <= w_wr_addr_next;
            r_wr_data    <= w_wr_data_next;
            r_clear_done <= w_clear_done_next;
        end
    end

    assign bus.draw_ready   = w_grant;
    assign bus.vram_wr_ena  = r_wr_ena;
    assign bus.vram_wr_addr = r_wr_addr;
    assign bus.vram_wr_data = r_wr_data;
    assign bus.busy         = (r_state == S_VRAM_CLEARING);
    assign bus.clear_done   = r_clear_done;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Randomised bench for vram_write_arbiter on a 4x3 display, checked against a
// queue-based reference model and a shadow copy of VRAM.
module tb_vram_write_arbiter;
    import vram_write_arbiter_pkg::*;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int L  = 12;
    localparam int AW = 4;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vram_write_arbiter_if #(.AW(AW), .VRAM_W(16)) bus ();

    vram_write_arbiter #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H),
        .VRAM_L         (L),
        .VRAM_W         (16),
        .CLEAR_COLOR    (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks;
    int n_errors;

    // Drive values for the current cycle.
    logic        d_clr;
    logic [1:0]  d_valid;
    int          d_x [2];
    int          d_y [2];
    logic [15:0] d_c [2];
    logic [1:0]  last_ready;

    // Reference model: pending clear addresses, tie preference, shadow memories.
    int          clear_q [$];
    int          pref;
    bit          known;
    logic [15:0] model_ram [L];
    logic [15:0] dut_ram [L];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_clear();
        clear_q.delete();
        for (int a = 0; a < L; a++) clear_q.push_back(a);
    endtask

    task automatic step(input bit do_rst);
        bit          e_ena;
        bit          e_done;
        int          e_addr;
        logic [15:0] e_data;
        logic [1:0]  e_ready;
        int          w;
        @(negedge clk);
        rst = do_rst;
        bus.clear_req  = d_clr;
        bus.draw_valid = d_valid;
        for (int i = 0; i < 2; i++) begin
            bus.draw[i].x     = 9'(d_x[i]);
            bus.draw[i].y     = 9'(d_y[i]);
            bus.draw[i].color = d_c[i];
        end
        #1;
        if (known && !do_rst) check_eq("busy", 32'(bus.busy), 32'(clear_q.size() != 0));
        e_ena = 1'b0; e_done = 1'b0; e_addr = 0; e_data = 16'h0000; e_ready = 2'b00;
        if (do_rst) begin
            fill_clear();
            pref  = 0;
            known = 1'b1;
        end else if (clear_q.size() != 0) begin
            e_ena  = 1'b1;
            e_addr = clear_q.pop_front();
            e_data = 16'h0000;
            e_done = (clear_q.size() == 0);
        end else if (d_clr) begin
            fill_clear();
        end else begin
            w = -1;
            if (d_valid == 2'b11) w = pref;
            else if (d_valid[0]) w = 0;
            else if (d_valid[1]) w = 1;
            if (w >= 0) begin
                e_ready[w] = 1'b1;
                pref = 1 - w;
                if (d_x[w] < W && d_y[w] < H) begin
                    e_ena  = 1'b1;
                    e_addr = d_y[w] * W + d_x[w];
                    e_data = d_c[w];
                end
            end
        end
        if (known) check_eq("ready", 32'(bus.draw_ready), 32'(e_ready));
        last_ready = bus.draw_ready;
        @(posedge clk);
        #1;
        if (known) begin
            check_eq("wr_ena", 32'(bus.vram_wr_ena), 32'(e_ena));
            check_eq("clear_done", 32'(bus.clear_done), 32'(e_done));
            if (e_ena) begin
                check_eq("wr_addr", 32'(bus.vram_wr_addr), 32'(e_addr));
                check_eq("wr_data", 32'(bus.vram_wr_data), 32'(e_data));
                model_ram[e_addr] = e_data;
            end
        end
        if (bus.vram_wr_ena === 1'b1 && int'(bus.vram_wr_addr) < L) dut_ram[bus.vram_wr_addr] = bus.vram_wr_data;
    endtask

    // Requesters drop a pixel once it has been handshaken.
    task automatic retire();
        for (int i = 0; i < 2; i++) if (d_valid[i] && last_ready[i]) d_valid[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input int x, input int y, input logic [15:0] c);
        d_valid[i] = 1'b1; d_x[i] = x; d_y[i] = y; d_c[i] = c;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; known = 1'b0; pref = 0;
        rst = 1'b1; d_clr = 1'b0; d_valid = 2'b00; last_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin d_x[i] = 0; d_y[i] = 0; d_c[i] = 16'h0000; end
        for (int a = 0; a < L; a++) begin model_ram[a] = 16'hDEAD; dut_ram[a] = 16'hDEAD; end

        // Power-up clear: 12 writes then the done pulse.
        step(1'b1);
        repeat (13) step(1'b0);

        // Single in-range pixel: (2,1) -> addr 6.
        set_req(0, 2, 1, 16'hF800);
        step(1'b0); retire();
        check_eq("req0_addr6", 32'(bus.vram_wr_addr), 32'd6);
        step(1'b0);

        // Serve requester 1 once so the following tie starts with requester 0.
        set_req(1, 1, 0, 16'h07E0);
        step(1'b0); retire();

        // Both held for 4 cycles: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 0, 0, 16'h1111);
            set_req(1, 3, 2, 16'h2222);
            step(1'b0);
        end
        d_valid = 2'b00;

        // Out-of-range pixel is consumed without a write; requester 1 follows.
        set_req(0, 4, 0, 16'h3333);
        set_req(1, 1, 1, 16'h4444);
        step(1'b0); retire();
        step(1'b0); retire();

        // clear_req beats a same-cycle draw, which is then served after the clear.
        set_req(0, 1, 2, 16'h5555);
        d_clr = 1'b1;
        step(1'b0); retire();
        d_clr = 1'b0;
        repeat (14) begin step(1'b0); retire(); end

        // Reset in the middle of a clear restarts from address 0; clear_req there is ignored.
        step(1'b1);
        repeat (5) step(1'b0);
        step(1'b1);
        step(1'b0);
        d_clr = 1'b1; step(1'b0); d_clr = 1'b0;
        repeat (12) step(1'b0);

        // Randomised traffic with occasional clears and resets.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!d_valid[i] && $urandom_range(0, 99) < 60) begin
                    d_valid[i] = 1'b1;
                    d_x[i] = ($urandom_range(0, 15) == 0) ? 511 : int'($urandom_range(0, W));
                    d_y[i] = int'($urandom_range(0, H));
                    d_c[i] = 16'($urandom);
                end
            end
            d_clr = ($urandom_range(0, 99) < 3);
            step($urandom_range(0, 499) == 0);
            retire();
        end
        d_clr = 1'b0; d_valid = 2'b00;
        repeat (14) step(1'b0);

        for (int a = 0; a < L; a++) check_eq($sformatf("ram[%0d]", a), 32'(dut_ram[a]), 32'(model_ram[a]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
